// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    // Operation encoding, identical to the RV32M funct3 field
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_t;

    // Divide and remainder ops share the top funct3 bit
    function automatic logic is_div_op(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on operand
// magnitudes (shift-add multiply, restoring divide), with the sign
// applied at the end. Divide-by-zero and signed overflow skip the loop.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     MOST_NEG   = {1'b1, {(W-1){1'b0}}};

    muldiv_state_t state;
    muldiv_state_t state_next;

    muldiv_op_t     op_q;
    logic [W:0]     acc;
    logic [W-1:0]   sreg;
    logic [W-1:0]   operand;
    logic [CNT_W-1:0] count;
    logic           neg_main;
    logic           neg_rem;

    muldiv_op_t     op_in;
    logic           op1_signed;
    logic           op2_signed;
    logic           op1_neg;
    logic           op2_neg;
    logic [W-1:0]   mag1;
    logic [W-1:0]   mag2;
    logic           fast_path;
    logic [W-1:0]   fast_value;

    logic [W:0]     mul_sum;
    logic [W:0]     acc_next;
    logic [W-1:0]   sreg_next;
    logic [W:0]     div_shift;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] product;
    logic [2*W-1:0] product_fixed;
    logic [W-1:0]   quotient_fixed;
    logic [W-1:0]   remainder_fixed;
    logic [W-1:0]   final_value;

    // Decode the incoming request: operand signs, magnitudes and the
    // divide-by-zero / signed-overflow shortcuts
    always_comb begin
        op_in      = muldiv_op_t'(op);
        op1_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                     (op_in == OP_DIV)  || (op_in == OP_REM);
        op2_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        op1_neg    = op1_signed && op1[W-1];
        op2_neg    = op2_signed && op2[W-1];
        mag1       = op1_neg ? -op1 : op1;
        mag2       = op2_neg ? -op2 : op2;
        fast_path  = 1'b0;
        fast_value = '0;
        if (is_div_op(op_in) && (op2 == '0)) begin
            fast_path  = 1'b1;
            fast_value = op_in[1] ? op1 : '1;
        end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (op1 == MOST_NEG) && (op2 == '1)) begin
            fast_path  = 1'b1;
            fast_value = op_in[1] ? '0 : op1;
        end
    end

    // One iteration step plus sign fix-up of the value the step produces
    always_comb begin
        mul_sum   = sreg[0] ? (acc + {1'b0, operand}) : acc;
        div_shift = {acc[W-1:0], sreg[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, operand};
        if (is_div_op(op_q)) begin
            if (div_diff[W+1]) begin
                acc_next  = div_shift;
                sreg_next = {sreg[W-2:0], 1'b0};
            end else begin
                acc_next  = div_diff[W:0];
                sreg_next = {sreg[W-2:0], 1'b1};
            end
        end else begin
            acc_next  = {1'b0, mul_sum[W:1]};
            sreg_next = {mul_sum[0], sreg[W-1:1]};
        end
        product         = {acc_next[W-1:0], sreg_next};
        product_fixed   = neg_main ? -product : product;
        quotient_fixed  = neg_main ? -sreg_next : sreg_next;
        remainder_fixed = neg_rem ? -acc_next[W-1:0] : acc_next[W-1:0];
        case (op_q)
            OP_MUL:                        final_value = product_fixed[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_value = product_fixed[2*W-1:W];
            OP_DIV, OP_DIVU:               final_value = quotient_fixed;
            default:                       final_value = remainder_fixed;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = fast_path ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (count == LAST_COUNT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch the request, iterate, and load the result on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MUL;
            acc      <= '0;
            sreg     <= '0;
            operand  <= '0;
            count    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q     <= op_in;
                        count    <= '0;
                        acc      <= '0;
                        neg_main <= op1_neg ^ op2_neg;
                        neg_rem  <= op1_neg;
                        if (fast_path) begin
                            result <= fast_value;
                        end else if (is_div_op(op_in)) begin
                            sreg    <= mag1;
                            operand <= mag2;
                        end else begin
                            sreg    <= mag2;
                            operand <= mag1;
                        end
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_next;
                    sreg  <= sreg_next;
                    count <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        result <= final_value;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign zero = (result == '0);

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op1  input  DATA_WIDTH  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port op2  input  DATA_WIDTH  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port busy  output  1  high while an accepted operation is in flight (BUSY or DONE).
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 SHALL have port result  output  DATA_WIDTH  registered result.
REQ-011 SHALL have port zero  output  1  high when result == 0.

Function
REQ-012 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; special cases IDLE -> DONE directly.
REQ-013 SHALL latch op, op1, op2 on the edge where start=1 in IDLE; later input changes SHALL not affect the operation.
REQ-014 SHALL ignore start in BUSY and DONE (no queueing, no restart).
REQ-015 SHALL take exactly DATA_WIDTH cycles in BUSY (one bit per cycle: shift-add multiply, restoring divide), so done is high in cycle t+DATA_WIDTH+1 for a start sampled at edge t.
REQ-016 SHALL handle signedness by magnitude operation plus final conditional negation; MULH signed x signed, MULHSU op1 signed x op2 unsigned, MULHU unsigned x unsigned.
REQ-017 SHALL compute the full 2*DATA_WIDTH product; MUL returns low half, MULH/MULHSU/MULHU return high half.
REQ-018 SHALL truncate quotient toward zero; remainder SHALL take the sign of the dividend.
REQ-019 SHALL on divide-by-zero return all-ones for DIV/DIVU and op1 for REM/REMU, via fast path: done in cycle t+1.
REQ-020 SHALL on signed overflow (DIV/REM, op1 = most-negative, op2 = all-ones) return op1 for DIV and 0 for REM, via fast path: done in cycle t+1.
REQ-021 SHALL update result only in the cycle done rises and hold it stable until the next done.
REQ-022 SHALL keep done low in all states except DONE; DONE lasts exactly one cycle.
REQ-023 SHALL derive zero combinationally from the result register.

Reset
REQ-024 SHALL on rst assertion immediately (no clock) force IDLE, busy=0, done=0, result=0, zero=1, clearing all datapath registers.
REQ-025 SHALL abandon an in-flight operation on reset mid-operation with no done pulse; a start after rst deasserts SHALL be accepted normally.

Structure
REQ-026 SHALL place op encoding enum (muldiv_op_t) and FSM state enum (muldiv_state_t) in shared package muldiv_pkg.
REQ-027 SHALL be a single module; no sub-module; one accumulator/remainder register, one shift register, one cycle counter of clog2(DATA_WIDTH+1) bits.

Verification (DATA_WIDTH=32, start sampled at edge t)
REQ-028 SHALL cover MUL op1=7, op2=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle t+33, busy high cycles t+1..t+33.
REQ-029 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000, zero=1.
REQ-030 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
REQ-031 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, done in cycle t+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, done in cycle t+1.
REQ-032 SHALL cover start pulsed in cycles t+5 and in the DONE cycle of a running MUL -> ignored, exactly one done, result unchanged.
REQ-033 SHALL cover rst asserted mid-cycle at t+10 of a DIV -> busy=0, done=0, result=0 before next edge; no done follows; next MUL 3x4 -> 12.
